cla_pipe: RTL and testbench
===========================

CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 SHALL have parameter BLK, default 4, carry-lookahead block width in bits; one block per pipeline stage.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port a, input, WIDTH, operand A.
REQ-006 SHALL have port b, input, WIDTH, operand B.
REQ-007 SHALL have port ci, input, 1, carry-in.
REQ-008 SHALL have port in_valid, input, 1, operands valid this cycle.
REQ-009 SHALL have port in_ready, output, 1, pipeline accepts operands this cycle.
REQ-010 SHALL have port s, output, WIDTH, registered sum.
REQ-011 SHALL have port co, output, 1, registered carry-out.
REQ-012 SHALL have port out_valid, output, 1, s/co hold a valid result.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the result this cycle.

Function
REQ-014 SHALL use NSTG = WIDTH/BLK stages; stage k adds operand bits [k*BLK+BLK-1 : k*BLK] with the carry registered by stage k-1 (stage 0 uses ci).
REQ-015 SHALL compute each slice with block generate/propagate lookahead, no ripple between bits inside a block.
REQ-016 SHALL skew inputs: upper operand slices delayed until their stage; completed lower sum slices delayed to align at the output.
REQ-017 SHALL produce {co,s} = a + b + ci modulo 2^(WIDTH+1), exactly.
REQ-018 SHALL have latency NSTG cycles from an accepted input (in_valid & in_ready) to out_valid, absent stalls.
REQ-019 SHALL sustain throughput of one operation per cycle when out_ready is held 1.
REQ-020 SHALL advance all stages together when adv = !out_valid | out_ready; in_ready SHALL equal adv.
REQ-021 SHALL hold every stage register, s, co and out_valid unchanged while adv = 0.
REQ-022 SHALL propagate bubbles (stage valid = 0) when in_valid = 0 during adv; bubbles are not collapsed.
REQ-023 SHALL hold s/co stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL ignore a, b, ci when in_valid & in_ready is 0.

Reset
REQ-025 SHALL on reset_n = 0 immediately clear all stage valid bits, stage data and carry registers, s, co and out_valid to 0.
REQ-026 SHALL discard in-flight operations on reset; first output after release comes NSTG cycles after the first accepted input.
REQ-027 SHALL drive in_ready = 1 during and directly after reset (pipeline empty).

Configuration
REQ-028 SHALL, with CLA_PIPE_OVF_EN defined, add output ovf (1 bit, registered, aligned with s) = carry into MSB xor carry out of MSB, reset 0, held on stall.
REQ-029 SHALL, without CLA_PIPE_OVF_EN, have no ovf port and no related logic; all other behaviour identical.

Structure
REQ-030 SHALL place BLK default, NSTG computation function and a stage record typedef (valid, partial sum, carry, skewed operands) in package cla_pkg.
REQ-031 SHALL implement one combinational sub-module cla_blk (BLK-bit lookahead adder: a, b, ci -> s, co) instantiated once per stage.
REQ-032 SHALL reject WIDTH not a multiple of BLK, or BLK < 1, at elaboration.

Verification (WIDTH=32, BLK=4, NSTG=8)
REQ-033 SHALL check a=0x00000003, b=0x00000005, ci=0 accepted at cycle 0 -> out_valid at cycle 8, s=0x00000008, co=0.
REQ-034 SHALL check a=0xFFFFFFFF, b=0x00000000, ci=1 -> s=0x00000000, co=1 (carry crosses all 8 stages).
REQ-035 SHALL check three back-to-back inputs (0x1+0x1, 0xFFFFFFFF+0xFFFFFFFF, 0x7+0x9 ci=1) -> results 0x2/0, 0xFFFFFFFE/1, 0x11/0 on cycles 8,9,10.
REQ-036 SHALL check out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, s/co frozen, no result lost or duplicated after release.
REQ-037 SHALL check reset_n pulsed low at cycle 4 with 4 ops in flight -> out_valid=0, s=0, co=0 immediately, no stale result afterwards.
REQ-038 SHALL check with CLA_PIPE_OVF_EN: 0x7FFFFFFF+0x00000001 -> ovf=1, co=0; 0xFFFFFFFF+0x00000001 -> ovf=0, co=1.

Source files
------------

// File: rtl/cla_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla_pkg : shared constants, stage-count helper and stage record       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cla_pkg;

    localparam int CLA_BLK_DEFAULT = 4;
    localparam int CLA_MAX_WIDTH   = 64;

    function automatic int cla_nstg(input int width, input int blk);
        if (blk < 1) begin
            return 0;
        end
        return width / blk;
    endfunction

    // Fields are sized for the widest supported adder; narrower instances leave upper bits at 0.
    typedef struct packed {
        logic                     valid;
        logic                     carry;
        logic [CLA_MAX_WIDTH-1:0] sum;
        logic [CLA_MAX_WIDTH-1:0] a;
        logic [CLA_MAX_WIDTH-1:0] b;
    } cla_stage_t;

endpackage
`default_nettype wire

// File: rtl/cla_blk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla_blk : combinational BLK-bit carry-lookahead adder slice           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cla_blk #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co
);

    logic [BLK-1:0] w_g;
    logic [BLK-1:0] w_p;
    logic [BLK:0]   w_c;
    logic           v_acc;
    logic           v_prod;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a flat sum of generate terms gated by the propagates above them.
    always_comb begin
        w_c    = '0;
        v_acc  = 1'b0;
        v_prod = 1'b1;
        for (int i = 0; i <= BLK; i++) begin
            v_acc  = 1'b0;
            v_prod = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                v_acc  = v_acc | (w_g[j] & v_prod);
                v_prod = v_prod & w_p[j];
            end
            w_c[i] = v_acc | (v_prod & ci);
        end
    end

    assign s  = w_p ^ w_c[BLK-1:0];
    assign co = w_c[BLK];

endmodule
`default_nettype wire

// File: rtl/cla_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla_pipe : pipelined carry-lookahead adder, one BLK slice per stage.  |
// | Define CLA_PIPE_OVF_EN to add the registered signed-overflow output.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLK   = CLA_BLK_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             out_valid,
    input  logic             out_ready
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTG = cla_nstg(WIDTH, BLK);

    if (BLK < 1) begin : g_bad_blk
        $error("cla_pipe: BLK must be at least 1");
    end else if ((WIDTH % BLK) != 0) begin : g_bad_width
        $error("cla_pipe: WIDTH must be a multiple of BLK");
    end else if (WIDTH > CLA_MAX_WIDTH) begin : g_too_wide
        $error("cla_pipe: WIDTH exceeds CLA_MAX_WIDTH");
    end

    logic       w_adv;
    cla_stage_t w_src;
    cla_stage_t w_stage [NSTG];
    logic       w_unused_last;

    // The last stage register doubles as the output register.
    assign w_adv     = !w_stage[NSTG-1].valid || out_ready;
    assign in_ready  = w_adv;
    assign s         = w_stage[NSTG-1].sum[WIDTH-1:0];
    assign co        = w_stage[NSTG-1].carry;
    assign out_valid = w_stage[NSTG-1].valid;

    assign w_unused_last = ^{w_stage[NSTG-1].a, w_stage[NSTG-1].b, w_stage[NSTG-1].sum};

    // Operands are zeroed unless presented, so bubbles carry no stale input data.
    always_comb begin
        w_src = '0;
        if (in_valid) begin
            w_src.valid          = 1'b1;
            w_src.carry          = ci;
            w_src.a[WIDTH-1:0]   = a;
            w_src.b[WIDTH-1:0]   = b;
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        cla_stage_t     w_prev;
        cla_stage_t     stage_d;
        cla_stage_t     stage_q;
        logic [BLK-1:0] w_blk_s;
        logic           w_blk_co;

        if (k == 0) begin : g_first
            assign w_prev = w_src;
        end else begin : g_next
            assign w_prev = w_stage[k-1];
        end

        cla_blk #(
            .BLK (BLK)
        ) u_blk (
            .a  (w_prev.a[k*BLK +: BLK]),
            .b  (w_prev.b[k*BLK +: BLK]),
            .ci (w_prev.carry),
            .s  (w_blk_s),
            .co (w_blk_co)
        );

        always_comb begin
            stage_d                   = w_prev;
            stage_d.sum[k*BLK +: BLK] = w_blk_s;
            stage_d.carry             = w_blk_co;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage_q <= '0;
            end else if (w_adv) begin
                stage_q <= stage_d;
            end
        end

        assign w_stage[k] = stage_q;

`ifdef CLA_PIPE_OVF_EN
        if (k == NSTG - 1) begin : g_ovf
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            assign ovf_d = w_prev.a[WIDTH-1] ^ w_prev.b[WIDTH-1] ^ w_blk_s[BLK-1] ^ w_blk_co;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ovf_q <= 1'b0;
                end else if (w_adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign ovf = ovf_q;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cla_pipe : scoreboard bench for cla_pipe (WIDTH=32, BLK=4)         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_cla_pipe;

    localparam int NSTG = 8;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;
    logic        ci        = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    wire         in_ready;
    wire  [31:0] s;
    wire         co;
    wire         out_valid;
`ifdef CLA_PIPE_OVF_EN
    wire         ovf;
`endif

    cla_pipe #(
        .WIDTH (32),
        .BLK   (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .co        (co),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed on the edge following a negedge that shows valid & ready.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got s=0x%0h co=%0b, expected no result", s, co);
            end else begin
                e = q.pop_front();
                check("result_s", {32'h0, s}, {32'h0, e.s});
                check("result_co", {63'h0, co}, {63'h0, e.co});
`ifdef CLA_PIPE_OVF_EN
                check("result_ovf", {63'h0, ovf}, {63'h0, e.ovf});
`endif
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tci,
                        input logic [31:0] es, input logic eco, input logic eovf);
        exp_t e;
        int   k;
        a        = ta;
        b        = tb_;
        ci       = tci;
        in_valid = 1'b1;
        k        = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1");
        end
        e.s   = es;
        e.co  = eco;
        e.ovf = eovf;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_queue_empty", 64'(q.size()), 64'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int run;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_s", {32'h0, s}, 64'h0);
        check("rst_co", {63'h0, co}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1;

        // Single op and latency
        send(32'h00000003, 32'h00000005, 1'b0, 32'h00000008, 1'b0, 1'b0);
        wait_valid(1, lat);
        check("latency_single", 64'(lat), 64'(NSTG));
        drain();

        // Carry through every stage
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        drain();

        // Back-to-back
        send(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
        send(32'h00000007, 32'h00000009, 1'b1, 32'h00000011, 1'b0, 1'b0);
        wait_valid(3, lat);
        check("latency_b2b", 64'(lat), 64'(NSTG));
        run = 0;
        repeat (3) begin
            if (out_valid) run++;
            @(posedge clk);
            #1;
        end
        check("b2b_valid_run", 64'(run), 64'd3);
        drain();

        // Bubbles with garbage on the operand bus
        send(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b0);
        idle(2);
        send(32'hFFFFFFF0, 32'h00000010, 1'b0, 32'h00000000, 1'b1, 1'b0);
        drain();

        // Output stall
        send(32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        send(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);
        out_ready = 1'b0;
        wait_valid(3, lat);
        for (int i = 0; i < 4; i++) begin
            check("stall_in_ready", {63'h0, in_ready}, 64'h0);
            check("stall_out_valid", {63'h0, out_valid}, 64'h1);
            check("stall_s", {32'h0, s}, 64'h30);
            check("stall_co", {63'h0, co}, 64'h0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Reset with operations in flight
        send(32'h00000100, 32'h00000200, 1'b0, 32'h00000300, 1'b0, 1'b0);
        send(32'h0000000A, 32'h0000000B, 1'b1, 32'h00000016, 1'b0, 1'b0);
        send(32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1, 1'b0);
        send(32'h55555555, 32'hAAAAAAAA, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        q.delete();
        check("inflight_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("inflight_rst_s", {32'h0, s}, 64'h23456789 & 64'h0);
        check("inflight_rst_co", {63'h0, co}, 64'h0);
        check("inflight_rst_in_ready", {63'h0, in_ready}, 64'h1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run = 0;
        repeat (12) begin
            if (out_valid) run++;
            @(posedge clk);
            #1;
        end
        check("no_stale_after_rst", 64'(run), 64'h0);
        send(32'h00001234, 32'h00004321, 1'b0, 32'h00005555, 1'b0, 1'b0);
        wait_valid(1, lat);
        check("latency_after_rst", 64'(lat), 64'(NSTG));
        drain();

`ifdef CLA_PIPE_OVF_EN
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
